// File: rtl/coord_pkg.sv
// Shared types, default widths and the saturation helper for the coordinate mapper.
package coord_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int SCALE_WIDTH_DEF = 24;
  localparam int OUT_WIDTH_DEF   = 32;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int SLACK_DEF       = 4;

  // Working width for the clamp helper; every intermediate sum must fit in it.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic sof;
    logic eol;
  } coord_sb_t;

  // Clamp a signed value to the range of a w-bit signed number.
  function automatic logic signed [SAT_W-1:0] sat_signed(input logic signed [SAT_W-1:0] v,
                                                         input int w);
    logic signed [SAT_W-1:0] mx;
    logic signed [SAT_W-1:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

endpackage

// File: rtl/coordinate_mapper_if.sv
// Input coordinate stream and output complex-point stream of the mapper.
interface coordinate_mapper_if
  import coord_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
);
  logic signed [DATA_WIDTH-1:0] x;
  logic signed [DATA_WIDTH-1:0] y;
  logic                         in_valid;
  logic                         in_sof;
  logic                         in_eol;
  logic                         in_ready;
  logic signed [OUT_WIDTH-1:0]  re;
  logic signed [OUT_WIDTH-1:0]  im;
  logic                         out_valid;
  logic                         out_sof;
  logic                         out_eol;
  logic                         out_ready;

  // Mapper side.
  modport slave (
    input  x, y, in_valid, in_sof, in_eol, out_ready,
    output in_ready, re, im, out_valid, out_sof, out_eol
  );

  // Producer/consumer side.
  modport master (
    output x, y, in_valid, in_sof, in_eol, out_ready,
    input  in_ready, re, im, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on dout whenever not empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage array; contents need no reset since empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/coordinate_mapper.sv
// Maps integer pixel coordinates to saturated fixed-point complex points:
// two non-stalling pipeline stages feeding a show-ahead output FIFO, with
// credit-based in_ready that leaves room for the producer's overrun.
module coordinate_mapper
  import coord_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SCALE_WIDTH = SCALE_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SLACK       = SLACK_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  coordinate_mapper_if.slave          bus,
  input  logic [SCALE_WIDTH-1:0]      scale,
  input  logic signed [OUT_WIDTH-1:0] offset_re,
  input  logic signed [OUT_WIDTH-1:0] offset_im,
  output logic                        overflow
);
  localparam int PW = DATA_WIDTH + SCALE_WIDTH + 1;
  localparam int SW = ((PW > OUT_WIDTH) ? PW : OUT_WIDTH) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int FW = 2 * OUT_WIDTH + 2;

  logic [SCALE_WIDTH-1:0]      cfg_scale, use_scale;
  logic signed [OUT_WIDTH-1:0] cfg_ore, cfg_oim, use_ore, use_oim;
  logic                        beat_sof;

  logic                        s1_vld, s2_vld;
  logic signed [PW-1:0]        s1_px, s1_py;
  logic signed [OUT_WIDTH-1:0] s1_ore, s1_oim, s2_re, s2_im;
  coord_sb_t                   s1_sb, s2_sb, head_sb;
  logic signed [SW-1:0]        sum_re, sum_im;

  logic [FW-1:0]               fifo_dout;
  logic                        full, empty, pop, push_ok;
  logic [CW-1:0]               fcount;
  logic [OW-1:0]               occ_next;

  // A sof beat uses the live config; every other beat uses the frame's latched copy.
  always_comb begin
    beat_sof  = bus.in_valid & bus.in_sof;
    use_scale = beat_sof ? scale     : cfg_scale;
    use_ore   = beat_sof ? offset_re : cfg_ore;
    use_oim   = beat_sof ? offset_im : cfg_oim;
  end

  // Latch config for the rest of the frame on each sof beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cfg_scale <= '0;
      cfg_ore   <= '0;
      cfg_oim   <= '0;
    end else if (beat_sof) begin
      cfg_scale <= scale;
      cfg_ore   <= offset_re;
      cfg_oim   <= offset_im;
    end
  end

  // Stage 1: full-width signed products; every in_valid cycle is a beat.
  always_ff @(posedge clk) begin
    if (!resetn) s1_vld <= 1'b0;
    else         s1_vld <= bus.in_valid;
    s1_px  <= PW'(bus.x) * PW'($signed({1'b0, use_scale}));
    s1_py  <= PW'(bus.y) * PW'($signed({1'b0, use_scale}));
    s1_ore <= use_ore;
    s1_oim <= use_oim;
    s1_sb  <= '{sof: bus.in_sof, eol: bus.in_eol};
  end

  always_comb begin
    sum_re = SW'(s1_ore) + SW'(s1_px);
    sum_im = SW'(s1_oim) + SW'(s1_py);
  end

  // Stage 2: offset add, clamped to the output range.
  always_ff @(posedge clk) begin
    if (!resetn) s2_vld <= 1'b0;
    else         s2_vld <= s1_vld;
    s2_re <= OUT_WIDTH'(sat_signed(SAT_W'(sum_re), OUT_WIDTH));
    s2_im <= OUT_WIDTH'(sat_signed(SAT_W'(sum_im), OUT_WIDTH));
    s2_sb <= s1_sb;
  end

  assign pop     = ~empty & bus.out_ready;
  assign push_ok = s2_vld & (~full | pop);

  sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (s2_vld),
    .pop    (pop),
    .din    ({s2_sb, s2_re, s2_im}),
    .dout   (fifo_dout),
    .full   (full),
    .empty  (empty),
    .count  (fcount)
  );

  assign head_sb = fifo_dout[FW-1 -: 2];

  // Head of FIFO drives the output stream; zeros while empty.
  always_comb begin
    bus.out_valid = ~empty;
    bus.re        = '0;
    bus.im        = '0;
    bus.out_sof   = 1'b0;
    bus.out_eol   = 1'b0;
    if (!empty) begin
      bus.re      = fifo_dout[2*OUT_WIDTH-1 -: OUT_WIDTH];
      bus.im      = fifo_dout[OUT_WIDTH-1:0];
      bus.out_sof = head_sb.sof;
      bus.out_eol = head_sb.eol;
    end
  end

  // Occupancy after this edge: FIFO plus both pipeline stages.
  assign occ_next = OW'(fcount) + OW'(push_ok) - OW'(pop) + OW'(bus.in_valid) + OW'(s1_vld);

  // Registered credit and sticky drop flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.in_ready <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      bus.in_ready <= (occ_next <= OW'(FIFO_DEPTH - SLACK));
      if (s2_vld && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_coordinate_mapper.sv
// Directed bench for coordinate_mapper: main 32-bit instance plus a 16-bit
// output instance for saturation.
module tb_coordinate_mapper;
  import coord_pkg::*;

  logic clk;
  logic resetn;
  logic [23:0]        scale, scale2;
  logic signed [31:0] offset_re, offset_im;
  logic signed [15:0] ore2, oim2;
  logic               overflow, overflow2;

  coordinate_mapper_if #(.DATA_WIDTH(16), .OUT_WIDTH(32)) bus ();
  coordinate_mapper_if #(.DATA_WIDTH(16), .OUT_WIDTH(16)) bus2 ();

  coordinate_mapper #(.DATA_WIDTH(16), .SCALE_WIDTH(24), .OUT_WIDTH(32),
                      .FIFO_DEPTH(16), .SLACK(4)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave), .scale(scale),
    .offset_re(offset_re), .offset_im(offset_im), .overflow(overflow));

  coordinate_mapper #(.DATA_WIDTH(16), .SCALE_WIDTH(24), .OUT_WIDTH(16),
                      .FIFO_DEPTH(16), .SLACK(4)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2.slave), .scale(scale2),
    .offset_re(ore2), .offset_im(oim2), .overflow(overflow2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  longint cre[$], cim[$], csof[$], ceol[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic sof, input logic eol, input int xv, input int yv);
    bus.in_valid = v;
    bus.in_sof   = sof;
    bus.in_eol   = eol;
    bus.x        = 16'(xv);
    bus.y        = 16'(yv);
  endtask

  // Pop n beats from the main instance into the capture queues, bounded by budget cycles.
  task automatic collect(input int n, input int budget, input string tag);
    cre.delete(); cim.delete(); csof.delete(); ceol.delete();
    bus.out_ready = 1'b1;
    for (int c = 0; c < budget && cre.size() < n; c++) begin
      if (bus.out_valid) begin
        cre.push_back(bus.re);
        cim.push_back(bus.im);
        csof.push_back(bus.out_sof);
        ceol.push_back(bus.out_eol);
      end
      tick();
    end
    chk(tag, cre.size(), n);
  endtask

  initial begin
    int sent, rcv, cyc;
    logic h1, h2, send;

    resetn = 1'b0;
    scale = '0; offset_re = '0; offset_im = '0;
    scale2 = '0; ore2 = '0; oim2 = '0;
    drive(0, 0, 0, 0, 0);
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0; bus2.in_sof = 1'b0; bus2.in_eol = 1'b0;
    bus2.x = '0; bus2.y = '0; bus2.out_ready = 1'b1;
    tick(); tick();

    // Reset state
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_re", bus.re, 0);
    chk("rst_im", bus.im, 0);
    chk("rst_sof_eol", {bus.out_sof, bus.out_eol}, 0);
    chk("rst_overflow", overflow, 0);
    resetn = 1'b1;
    tick();
    chk("rdy_after_release", bus.in_ready, 1);

    // Basic map with latency: beat driven after edge N, visible after N+3
    bus.out_ready = 1'b1;
    scale = 24'd3; offset_re = 32'sd100; offset_im = -32'sd50;
    drive(1, 1, 0, -1024, 1024);
    tick(); drive(0, 0, 0, 0, 0);
    chk("lat_n1", bus.out_valid, 0);
    tick();
    chk("lat_n2", bus.out_valid, 0);
    tick();
    chk("lat_n3", bus.out_valid, 1);
    chk("basic_re", bus.re, -2972);
    chk("basic_im", bus.im, 3022);
    chk("basic_sof", bus.out_sof, 1);
    chk("basic_eol", bus.out_eol, 0);
    tick();
    chk("basic_popped", bus.out_valid, 0);

    // Saturation on the 16-bit instance
    scale2 = 24'd100;
    bus2.in_valid = 1'b1; bus2.in_sof = 1'b1; bus2.x = 16'sd1000; bus2.y = 16'sd0;
    tick();
    bus2.in_sof = 1'b0; bus2.x = -16'sd1000;
    tick();
    bus2.in_valid = 1'b0;
    tick();
    chk("sat_valid", bus2.out_valid, 1);
    chk("sat_pos_re", bus2.re, 32767);
    chk("sat_pos_im", bus2.im, 0);
    tick();
    chk("sat_neg_valid", bus2.out_valid, 1);
    chk("sat_neg_re", bus2.re, -32768);
    chk("sat_neg_im", bus2.im, 0);
    chk("sat_overflow", overflow2, 0);

    // Config latch: scale 2 for the frame despite mid-frame change to 5
    bus.out_ready = 1'b0;
    offset_re = '0; offset_im = '0;
    scale = 24'd2;
    drive(1, 1, 0, 10, 1); tick();
    scale = 24'd5;
    drive(1, 0, 0, 10, 1); tick();
    drive(1, 0, 0, 10, 1); tick();
    drive(1, 1, 0, 10, 1); tick();
    drive(0, 0, 0, 0, 0);
    collect(4, 30, "cfg_count");
    if (cre.size() == 4) begin
      chk("cfg_b0_re", cre[0], 20); chk("cfg_b0_im", cim[0], 2);
      chk("cfg_b1_re", cre[1], 20); chk("cfg_b2_re", cre[2], 20);
      chk("cfg_b3_re", cre[3], 50); chk("cfg_b3_im", cim[3], 5);
      chk("cfg_b3_sof", csof[3], 1);
    end

    // Backpressure: 2048-beat line, producer overruns up to 2 beats after in_ready falls
    scale = 24'd1;
    sent = 0; rcv = 0; cyc = 0; h1 = 1'b0; h2 = 1'b0;
    while (rcv < 2048 && cyc < 12000) begin
      bus.out_ready = (cyc >= 60);
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_re", bus.re, rcv);
        chk("bp_im", bus.im, -rcv);
        chk("bp_sof", bus.out_sof, (rcv == 0));
        chk("bp_eol", bus.out_eol, (rcv == 2047));
        rcv++;
      end
      if (cyc == 59) begin
        // 13 beats bring occupancy past 12, then 2 overrun beats follow
        chk("bp_sent_at_stall", sent, 15);
        chk("bp_rdy_low", bus.in_ready, 0);
        chk("bp_no_overflow", overflow, 0);
      end
      send = (sent < 2048) && (bus.in_ready || h1 || h2);
      h2 = h1;
      h1 = bus.in_ready;
      if (send) begin
        drive(1, sent == 0, sent == 2047, sent, -sent);
        sent++;
      end else begin
        drive(0, 0, 0, 0, 0);
      end
      tick();
      cyc++;
    end
    drive(0, 0, 0, 0, 0);
    chk("bp_received", rcv, 2048);
    chk("bp_overflow_end", overflow, 0);

    // Forced overflow: 20 beats into a stalled 16-entry FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1, i == 0, 0, i, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    chk("ovf_set", overflow, 1);
    collect(16, 40, "ovf_count");
    if (cre.size() == 16)
      for (int i = 0; i < 16; i++) chk("ovf_contents", cre[i], i);
    chk("ovf_drained", bus.out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // Reset mid-stream with 10 beats buffered
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1, i == 0, 0, 200 + i, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    tick(); tick(); tick();
    chk("mid_buffered", bus.out_valid, 1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_rdy", bus.in_ready, 0);
    chk("mid_rst_re", bus.re, 0);
    resetn = 1'b1;
    tick();
    chk("mid_rel_rdy", bus.in_ready, 1);
    chk("mid_rel_valid", bus.out_valid, 0);
    scale = 24'd1;
    drive(1, 1, 1, 77, 7); tick();
    drive(0, 0, 0, 0, 0);
    collect(1, 10, "mid_new_count");
    if (cre.size() == 1) begin
      chk("mid_new_re", cre[0], 77);
      chk("mid_new_im", cim[0], 7);
    end
    tick();
    chk("mid_no_stale", bus.out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
